// File: rtl/config_loader_pkg.sv
// Shared types and default sizing for the configuration loader.
package config_loader_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/config_loader_if.sv
// Host word handshake between a configuration source and the loader.
interface config_loader_if #(
    parameter int WORD_W = 32
) ();

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/config_serializer.sv
// Turns one host word into an MSB-first bit stream; bit_out is a flop output.
module config_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [WORD_W-1:0] data,
    output logic              bit_out,
    output logic              empty
);

    localparam int LW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sh_r;
    logic [LW-1:0]     left_r;
    logic              bit_r;

    // Word register: left_r counts bits still queued behind the one on bit_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r   <= {WORD_W{1'b0}};
            left_r <= {LW{1'b0}};
            bit_r  <= 1'b0;
        end else if (clear) begin
            sh_r   <= {WORD_W{1'b0}};
            left_r <= {LW{1'b0}};
            bit_r  <= 1'b0;
        end else if (load) begin
            bit_r  <= data[WORD_W-1];
            sh_r   <= data << 1;
            left_r <= LW'(WORD_W - 1);
        end else if (shift) begin
            bit_r  <= sh_r[WORD_W-1];
            sh_r   <= sh_r << 1;
            left_r <= left_r - LW'(1);
        end else begin
            sh_r   <= sh_r;
            left_r <= left_r;
            bit_r  <= bit_r;
        end
    end

    assign bit_out = bit_r;
    assign empty   = (left_r == LW'(0));

endmodule

// File: rtl/config_loader.sv
// Streams host words into a serial configuration chain, then latches it.
// Optional readback of the chain tail is enabled with CONFIG_LOADER_READBACK_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    config_loader_if.slave    host,
    output logic              shift_in_out,
    output logic              cen,
    output logic              cset,
    input  logic              chain_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    state_t           state_r;
    logic             in_ready_r;
    logic             cen_r;
    logic             cset_r;
    logic             done_r;
    logic             busy_r;
    logic [CNT_W-1:0] bit_cnt_r;

    logic             accept_s;
    logic             last_s;
    logic             ser_empty_s;
    logic             ser_shift_s;
    logic             ser_clear_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // bit_cnt_r counts bits already presented, including the one on the wire now.
    assign accept_s    = (state_r == ST_LOAD) && in_ready_r && host.in_valid;
    assign last_s      = (state_r == ST_SHIFT) && (bit_cnt_r == CHAIN_LEN_C);
    assign cnt_inc_s   = (bit_cnt_r == CHAIN_LEN_C) ? bit_cnt_r : bit_cnt_r + CNT_W'(1);
    assign ser_shift_s = (state_r == ST_SHIFT) && !last_s && !ser_empty_s;
    assign ser_clear_s = (state_r == ST_SHIFT) && (last_s || ser_empty_s);

    config_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .shift   (ser_shift_s),
        .clear   (ser_clear_s),
        .data    (host.in_data),
        .bit_out (shift_in_out),
        .empty   (ser_empty_s)
    );

    // Load sequencer; every handshake and strobe output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            cen_r      <= 1'b0;
            cset_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            bit_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        bit_cnt_r  <= {CNT_W{1'b0}};
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        state_r    <= ST_SHIFT;
                        in_ready_r <= 1'b0;
                        cen_r      <= 1'b1;
                        bit_cnt_r  <= cnt_inc_s;
                    end else begin
                        cen_r      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (last_s) begin
                        state_r <= ST_SET;
                        cen_r   <= 1'b0;
                        cset_r  <= 1'b1;
                    end else if (ser_empty_s) begin
                        state_r    <= ST_LOAD;
                        cen_r      <= 1'b0;
                        in_ready_r <= 1'b1;
                    end else begin
                        bit_cnt_r <= cnt_inc_s;
                    end
                end
                ST_SET: begin
                    state_r <= ST_DONE;
                    cset_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    cen_r      <= 1'b0;
                    cset_r     <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    bit_cnt_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign host.in_ready = in_ready_r;
    assign cen           = cen_r;
    assign cset          = cset_r;
    assign done          = done_r;
    assign busy          = busy_r;

`ifdef CONFIG_LOADER_READBACK_EN
    localparam int LW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] rb_sh_r;
    logic [WORD_W-1:0] rb_data_r;
    logic [LW-1:0]     rb_cnt_r;
    logic              rb_valid_r;
    logic [WORD_W-1:0] rb_next_s;

    assign rb_next_s = {rb_sh_r[WORD_W-2:0], chain_tail};

    // Readback capture; the last partial word is left-aligned by the remaining gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_sh_r    <= {WORD_W{1'b0}};
            rb_data_r  <= {WORD_W{1'b0}};
            rb_cnt_r   <= {LW{1'b0}};
            rb_valid_r <= 1'b0;
        end else if (cen_r) begin
            if ((rb_cnt_r == LW'(WORD_W - 1)) || last_s) begin
                rb_data_r  <= rb_next_s << (LW'(WORD_W - 1) - rb_cnt_r);
                rb_valid_r <= 1'b1;
                rb_sh_r    <= {WORD_W{1'b0}};
                rb_cnt_r   <= {LW{1'b0}};
            end else begin
                rb_sh_r    <= rb_next_s;
                rb_cnt_r   <= rb_cnt_r + LW'(1);
                rb_valid_r <= 1'b0;
            end
        end else if (state_r == ST_IDLE) begin
            rb_sh_r    <= {WORD_W{1'b0}};
            rb_cnt_r   <= {LW{1'b0}};
            rb_valid_r <= 1'b0;
        end else begin
            rb_valid_r <= 1'b0;
        end
    end

    assign rb_data  = rb_data_r;
    assign rb_valid = rb_valid_r;
`else
    logic unused_tail_s;

    assign unused_tail_s = chain_tail;
    assign rb_data       = {WORD_W{1'b0}};
    assign rb_valid      = 1'b0;
`endif

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WORD_W, default 32: width of each host configuration word.
REQ-002 Parameter CHAIN_LEN, default 1024: total configuration bits in the downstream tile chain.
REQ-003 Parameter CNT_W, default $clog2(CHAIN_LEN+1): width of the bit counter.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begins a load when sampled high in IDLE.
REQ-007 in_data  input  WORD_W  configuration word from the host.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 shift_in_out  output  1  serial bit; drives the chain's shift_in.
REQ-011 cen  output  1  shift enable; drives the chain's cen.
REQ-012 cset  output  1  latch pulse; drives the chain's cset.
REQ-013 chain_tail  input  1  shift_out of the last tile in the chain.
REQ-014 rb_data  output  WORD_W  readback word.
REQ-015 rb_valid  output  1  rb_data is valid for one cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a load completes.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, SHIFT, SET and DONE.
- IDLE->LOAD: start=1.
- LOAD->SHIFT: handshake.
- SHIFT->LOAD: word exhausted and bits remain.
- SHIFT->SET: CHAIN_LEN bits sent.
- SET->DONE: unconditional.
- DONE->IDLE: unconditional.
REQ-019 in_ready SHALL be high only in LOAD; a word is accepted on the cycle in_valid&&in_ready.
REQ-020 A word accepted at cycle k SHALL present its MSB on shift_in_out with cen=1 at cycle k+1, then one bit per cycle, MSB first.
REQ-021 shift_in_out and cen SHALL be registered and change together; cen SHALL be low outside SHIFT.
REQ-022 Exactly CHAIN_LEN cycles with cen=1 SHALL occur per load; the final word shifts only its top (CHAIN_LEN mod WORD_W) bits when that value is nonzero, and the remaining bits are discarded.
REQ-023 The number of words accepted per load SHALL be ceil(CHAIN_LEN/WORD_W).
REQ-024 After the last cen cycle L, cset SHALL be high for exactly cycle L+1 and done high for exactly cycle L+2, and the FSM SHALL then return to IDLE.
REQ-025 A start asserted while busy=1 SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-026 Host stalls (in_valid low in LOAD) SHALL hold cen low and keep the bit count unchanged.
REQ-027 The bit counter SHALL saturate at CHAIN_LEN and never wrap.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE and in_ready, shift_in_out, cen, cset, rb_valid, busy and done SHALL be 0, with rb_data and all counters cleared.
REQ-029 Reset mid-load SHALL abort immediately without pulsing cset; the partially shifted chain contents SHALL be left unlatched.

Configuration
REQ-030 With macro CONFIG_LOADER_READBACK_EN defined, chain_tail SHALL be sampled on each cen=1 cycle into a WORD_W shift register, MSB first.
- rb_valid SHALL pulse on the cycle a full word completes, and also for the final partial word, which is left-aligned and zero-padded.
- rb_valid SHALL NOT be subject to backpressure.
REQ-031 Without CONFIG_LOADER_READBACK_EN, rb_valid and rb_data SHALL be constant 0, chain_tail SHALL be ignored, and no readback logic SHALL be synthesised.

Structure
REQ-032 A shared package config_loader_pkg SHALL hold the FSM state enumeration and the default WORD_W and CHAIN_LEN constants.
REQ-033 Word-to-bit serialisation SHALL live in one sub-module, config_serializer (load, shift, bit out, empty); the FSM and counters stay in config_loader.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- CHAIN_LEN=40, WORD_W=32, words 0xA5A5A5A5 and 0xFF000000 -> 40 cen cycles; bits are 0xA5A5A5A5 MSB-first then eight 1s; cset at L+1; done at L+2.
- Host drops in_valid for 5 cycles between words -> cen low for those cycles; total cen count is still 40; stream is unchanged.
- start pulsed at shift bit 10 -> ignored; exactly one cset and one done.
- rst asserted at shift bit 20 -> all outputs 0 next cycle; no cset; next start loads correctly from bit 0.
- READBACK_EN, chain modelled as a 40-bit shift register preloaded with 0x12_3456_789A -> rb_data 0x12345678, then 0x9A000000, each with a one-cycle rb_valid.
- Macro undefined, chain_tail toggling -> rb_valid remains 0 throughout.
